// File: rtl/scope_pkg.sv
// Shared types and default sizes for the scope trigger/capture stage.
package scope_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 640;
  localparam int unsigned ADDR_W = 10;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FULL    = 2'd3
  } state_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port capture buffer: one write port, registered read port, read-old-data on collision.
module scope_capture_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read in one block so a same-address read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture.sv
// Level-crossing trigger and decimated one-frame capture for the VGA waveform view.
// Optional forced trigger after AUTO_TIMEOUT armed samples: define SCOPE_AUTO_TRIG_EN.
import scope_pkg::*;

module scope_capture #(
  parameter int unsigned DATA_W       = scope_pkg::DATA_W,
  parameter int unsigned DEPTH        = scope_pkg::DEPTH,
`ifdef SCOPE_AUTO_TRIG_EN
  parameter int unsigned AUTO_TIMEOUT = 65535,
`endif
  parameter int unsigned ADDR_W       = scope_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              armed,
  output logic              triggered
);

  localparam int unsigned DEC_W = 8;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   lvl_q, lvl_d;
  logic                rise_q, rise_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic [DEC_W-1:0]    dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                pv_q, pv_d;
  logic                trig_c;
  logic                cross_c;
  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic                rd_ok_c;
  logic                rd_ok_q;
  logic [ADDR_W-1:0]   raddr_c;
  logic [DATA_W-1:0]   ram_q;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int unsigned TO_W = 16;
  logic [TO_W-1:0]     to_q, to_d;
  logic                force_c;
`endif

  // Crossing test against the latched settings; needs a predecessor sample.
  always_comb begin
    cross_c = 1'b0;
    if (pv_q) begin
      if (rise_q) cross_c = (prev_q < lvl_q) && (sample_in >= lvl_q);
      else        cross_c = (prev_q > lvl_q) && (sample_in <= lvl_q);
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    rise_d  = rise_q;
    dec_d   = dec_q;
    dcnt_d  = dcnt_q;
    ptr_d   = ptr_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    trig_c  = 1'b0;
    we_c    = 1'b0;
    waddr_c = ptr_q;
`ifdef SCOPE_AUTO_TRIG_EN
    to_d    = to_q;
    force_c = 1'b0;
`endif
    case (state_q)
      IDLE, FULL: begin
        if (arm) begin
          state_d = ARMED;
          lvl_d   = trig_level;
          rise_d  = trig_rising;
          dec_d   = decim;
          pv_d    = 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
          to_d    = '0;
`endif
        end
      end
      ARMED: begin
        if (sample_valid) begin
          prev_d = sample_in;
          pv_d   = 1'b1;
`ifdef SCOPE_AUTO_TRIG_EN
          to_d    = to_q + TO_W'(1);
          force_c = (to_q == TO_W'(AUTO_TIMEOUT - 1));
          trig_c  = cross_c || force_c;
`else
          trig_c  = cross_c;
`endif
          if (trig_c) begin
            we_c    = 1'b1;
            waddr_c = '0;
            ptr_d   = ADDR_W'(1);
            dcnt_d  = '0;
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          if (dcnt_q == dec_q) begin
            we_c   = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
            dcnt_d = '0;
            if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = FULL;
          end else begin
            dcnt_d = dcnt_q + DEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      rise_q    <= 1'b0;
      dec_q     <= '0;
      dcnt_q    <= '0;
      ptr_q     <= '0;
      prev_q    <= '0;
      pv_q      <= 1'b0;
      full      <= 1'b0;
      armed     <= 1'b0;
      triggered <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      rise_q    <= rise_d;
      dec_q     <= dec_d;
      dcnt_q    <= dcnt_d;
      ptr_q     <= ptr_d;
      prev_q    <= prev_d;
      pv_q      <= pv_d;
      full      <= (state_d == FULL);
      armed     <= (state_d == ARMED);
      triggered <= trig_c;
`ifdef SCOPE_AUTO_TRIG_EN
      to_q      <= to_d;
`endif
    end
  end

  // Out-of-range columns read as zero; the flag is registered alongside the RAM output.
  assign rd_ok_c = (rd_addr < ADDR_W'(DEPTH));
  assign raddr_c = rd_ok_c ? rd_addr : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_ok_q <= 1'b0;
    else          rd_ok_q <= rd_ok_c;
  end

  assign rd_data = rd_ok_q ? ram_q : '0;

  scope_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (sample_in),
    .raddr (raddr_c),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: triggers, decimation, arm handling, read port, auto trigger.
module tb_scope_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        arm;
  logic [11:0] trig_level;
  logic        trig_rising;
  logic [7:0]  decim;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic        full;
  logic        armed;
  logic        triggered;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

`ifdef SCOPE_AUTO_TRIG_EN
  scope_capture #(.AUTO_TIMEOUT(16)) dut (
`else
  scope_capture dut (
`endif
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .decim        (decim),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .full         (full),
    .armed        (armed),
    .triggered    (triggered)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [11:0] d);
    rd_addr = a;
    step();
    d = rd_data;
  endtask

  // Pulse arm with the given settings, then scramble the live inputs.
  task automatic do_arm(input logic [11:0] lvl, input logic rise, input logic [7:0] dec);
    trig_level  = lvl;
    trig_rising = rise;
    decim       = dec;
    arm         = 1'b1;
    step();
    arm         = 1'b0;
    trig_level  = ~lvl;
    trig_rising = ~rise;
    decim       = ~dec;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #5;
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed: got %b want 0", armed); end
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b want 0", triggered); end
    n_vec++; if (rd_data !== 12'h000) begin n_err++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    step();
    reset_n = 1'b1;
    step();
    step();
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL idle_armed: got %b want 0", armed); end
  endtask

  task automatic test_rising();
    logic [11:0] d;
    do_reset();
    do_arm(12'h800, 1'b1, 8'd0);
    n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL rise_armed: got %b want 1", armed); end
    send(12'h7F0);
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL rise_first: got %b want 0", triggered); end
    send(12'h7F8);
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL rise_below: got %b want 0", triggered); end
    send(12'h800);
    n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL rise_trig: got %b want 1", triggered); end
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL rise_armed_drop: got %b want 0", armed); end
    step();
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL rise_pulse: got %b want 0", triggered); end
    for (int k = 1; k <= 639; k++) begin
      send(12'(32'h800 + k * 8));
      if (k == 638) begin
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rise_full_early: got %b want 0", full); end
      end
      if (k == 639) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL rise_full: got %b want 1", full); end
      end
    end
    rd(10'd0, d);
    n_vec++; if (d !== 12'h800) begin n_err++; $display("FAIL rise_buf0: got %h want 800", d); end
    rd(10'd639, d);
    n_vec++; if (d !== 12'hBF8) begin n_err++; $display("FAIL rise_buf639: got %h want bf8", d); end
    rd_addr = 10'd5;
    #1;
    n_vec++; if (rd_data !== 12'hBF8) begin n_err++; $display("FAIL rd_latency_hold: got %h want bf8", rd_data); end
    step();
    n_vec++; if (rd_data !== 12'h828) begin n_err++; $display("FAIL rd_buf5: got %h want 828", rd_data); end
    rd(10'd700, d);
    n_vec++; if (d !== 12'h000) begin n_err++; $display("FAIL rd_oob: got %h want 000", d); end
  endtask

  task automatic test_falling_and_arm();
    logic [11:0] d;
    do_reset();
    do_arm(12'h400, 1'b0, 8'd0);
    send(12'h500);
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL fall_first: got %b want 0", triggered); end
    send(12'h400);
    n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL fall_eq_trig: got %b want 1", triggered); end
    for (int k = 1; k <= 639; k++) begin
      send(12'h300);
      if (k == 639) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fall_full: got %b want 1", full); end
      end
    end
    rd(10'd0, d);
    n_vec++; if (d !== 12'h400) begin n_err++; $display("FAIL fall_buf0: got %h want 400", d); end
    // Re-arm from FULL
    do_arm(12'h400, 1'b0, 8'd0);
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rearm_full: got %b want 0", full); end
    n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL rearm_armed: got %b want 1", armed); end
    send(12'h400);
    send(12'h3FF);
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL fall_prev_eq: got %b want 0", triggered); end
    send(12'h401);
    send(12'h400);
    n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL fall_trig2: got %b want 1", triggered); end
    // arm during CAPTURE must be ignored
    do_arm(12'h800, 1'b1, 8'd5);
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL cap_arm_ignored: got %b want 0", armed); end
    for (int k = 1; k <= 639; k++) begin
      send(12'(k));
      if (k == 638) begin
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL cap_full_early: got %b want 0", full); end
      end
      if (k == 639) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL cap_full: got %b want 1", full); end
      end
    end
    rd(10'd0, d);
    n_vec++; if (d !== 12'h400) begin n_err++; $display("FAIL cap_buf0: got %h want 400", d); end
    rd(10'd1, d);
    n_vec++; if (d !== 12'h001) begin n_err++; $display("FAIL cap_buf1: got %h want 001", d); end
    rd(10'd639, d);
    n_vec++; if (d !== 12'h27F) begin n_err++; $display("FAIL cap_buf639: got %h want 27f", d); end
  endtask

  task automatic test_decim();
    logic [11:0] d;
    do_reset();
    do_arm(12'h100, 1'b1, 8'd3);
    send(12'h0F0);
    send(12'h100);
    n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL dec_trig: got %b want 1", triggered); end
    for (int j = 1; j <= 2556; j++) begin
      send(12'(32'h100 + j));
      if (j == 2555) begin
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL dec_full_early: got %b want 0", full); end
      end
      if (j == 2556) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL dec_full: got %b want 1", full); end
      end
    end
    rd(10'd1, d);
    n_vec++; if (d !== 12'h104) begin n_err++; $display("FAIL dec_buf1: got %h want 104", d); end
    rd(10'd100, d);
    n_vec++; if (d !== 12'h290) begin n_err++; $display("FAIL dec_buf100: got %h want 290", d); end
    rd(10'd639, d);
    n_vec++; if (d !== 12'hAFC) begin n_err++; $display("FAIL dec_buf639: got %h want afc", d); end
  endtask

  task automatic test_reset_mid_capture();
    logic [11:0] d;
    do_reset();
    do_arm(12'h100, 1'b1, 8'd0);
    rd_addr = 10'd0;
    send(12'h0F0);
    send(12'h200);
    send(12'h201);
    reset_n = 1'b0;
    #2;
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_cap_full: got %b want 0", full); end
    n_vec++; if (armed !== 1'b0) begin n_err++; $display("FAIL rst_cap_armed: got %b want 0", armed); end
    n_vec++; if (rd_data !== 12'h000) begin n_err++; $display("FAIL rst_cap_rd: got %h want 000", rd_data); end
    #5;
    reset_n = 1'b1;
    step();
    rd(10'd0, d);
    n_vec++; if (d !== 12'h200) begin n_err++; $display("FAIL rst_cap_keep: got %h want 200", d); end
    send(12'h050);
    send(12'h300);
    n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL rst_idle_notrig: got %b want 0", triggered); end
  endtask

`ifdef SCOPE_AUTO_TRIG_EN
  task automatic test_auto_trig();
    logic [11:0] d;
    do_reset();
    do_arm(12'h800, 1'b1, 8'd0);
    for (int i = 1; i <= 16; i++) begin
      send(12'h100);
      if (i == 15) begin
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL auto_early: got %b want 0", triggered); end
      end
      if (i == 16) begin
        n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL auto_trig: got %b want 1", triggered); end
      end
    end
    for (int k = 1; k <= 639; k++) begin
      send(12'h100);
      if (k == 638) begin
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL auto_full_early: got %b want 0", full); end
      end
      if (k == 639) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL auto_full: got %b want 1", full); end
      end
    end
    rd(10'd0, d);
    n_vec++; if (d !== 12'h100) begin n_err++; $display("FAIL auto_buf0: got %h want 100", d); end
    rd(10'd639, d);
    n_vec++; if (d !== 12'h100) begin n_err++; $display("FAIL auto_buf639: got %h want 100", d); end
  endtask
`else
  task automatic test_no_auto_trig();
    do_reset();
    do_arm(12'h800, 1'b1, 8'd0);
    for (int i = 1; i <= 40; i++) begin
      send(12'h100);
      if (i == 40) begin
        n_vec++; if (armed !== 1'b1) begin n_err++; $display("FAIL noauto_armed: got %b want 1", armed); end
      end
    end
  endtask
`endif

  initial begin
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    trig_level   = '0;
    trig_rising  = 1'b0;
    decim        = '0;
    rd_addr      = '0;
    test_reset();
    test_rising();
    test_falling_and_arm();
    test_decim();
    test_reset_mid_capture();
`ifdef SCOPE_AUTO_TRIG_EN
    test_auto_trig();
`else
    test_no_auto_trig();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
